// File: rtl/axi_slave_mem_arb.sv
// axi_slave_mem_arb: arbitrates the write-path and read-path command streams of
// the AXI slave onto one single-port memory stub. Grants are same-cycle
// valid/ready handshakes; the winning command is registered onto the memory port
// one cycle later and read data returns in order two cycles after acceptance.
module axi_slave_mem_arb #(
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BITS  = 64,
    parameter bit WR_PRIO    = 1'b0,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic [DATA_BITS/8-1:0] wr_bsel,
    output logic                   wr_ready,
    input  logic                   rd_req,
    input  logic [ADDR_BITS-1:0]   rd_addr,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   mem_wr,
    output logic                   mem_rd,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_din,
    output logic [DATA_BITS/8-1:0] mem_bsel,
    input  logic [DATA_BITS-1:0]   mem_dout,
    output logic [31:0]            wr_cnt,
    output logic [31:0]            rd_cnt,
    output logic                   idle
);

    localparam int         BSEL_BITS  = DATA_BITS / 8;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Which side won the most recent transfer; drives round-robin tie-breaks.
    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_e;

    gnt_e                 last_gnt_q, last_gnt_d;
    logic [7:0]           starve_cnt_q, starve_cnt_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_din_q, mem_din_d;
    logic [BSEL_BITS-1:0] mem_bsel_q, mem_bsel_d;
    logic [31:0]          wr_cnt_q, wr_cnt_d;
    logic [31:0]          rd_cnt_q, rd_cnt_d;

    logic wr_gnt;
    logic rd_gnt;

    // Grant decision: a lone requester always wins; ties use the configured policy.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_req && rd_req) begin
            if (WR_PRIO) begin
                if (starve_cnt_q == STARVE_LIM) rd_gnt = 1'b1;
                else                            wr_gnt = 1'b1;
            end else begin
                if (last_gnt_q == GNT_RD) wr_gnt = 1'b1;
                else                      rd_gnt = 1'b1;
            end
        end else begin
            wr_gnt = wr_req;
            rd_gnt = rd_req;
        end
    end

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Next-state: capture the granted command, advance counters and arbitration state.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_wr_d     = wr_gnt;
        mem_rd_d     = rd_gnt;
        rd_valid_d   = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_bsel_d   = mem_bsel_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;

        if (wr_gnt) begin
            last_gnt_d = GNT_WR;
            mem_addr_d = wr_addr;
            mem_din_d  = wr_data;
            mem_bsel_d = wr_bsel;
            wr_cnt_d   = wr_cnt_q + 32'd1;
        end else if (rd_gnt) begin
            // Reads only move the address; din/bsel keep the last write payload.
            last_gnt_d = GNT_RD;
            mem_addr_d = rd_addr;
            rd_cnt_d   = rd_cnt_q + 32'd1;
        end

        // Starvation counter only matters under write priority; it saturates at the
        // limit, where the read is guaranteed to win the next tie.
        if (!WR_PRIO || !rd_req || rd_gnt) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // State register; reset drops any read in flight along with the strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q   <= GNT_RD;
            starve_cnt_q <= 8'd0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_bsel_q   <= '0;
            wr_cnt_q     <= 32'd0;
            rd_cnt_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge value of every other, independent of statement order.
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            rd_valid_q   <= rd_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_bsel_q   <= mem_bsel_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_bsel = mem_bsel_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_dout;
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
    assign idle     = ~wr_req & ~rd_req & ~mem_wr_q & ~mem_rd_q & ~rd_valid_q;

endmodule

// File: tb/tb_axi_slave_mem_arb.sv
// Directed bench for axi_slave_mem_arb: a round-robin instance (a_*) and a
// write-priority instance (b_*) share the same stimulus; a small memory stub
// behind instance a returns read data one cycle after mem_rd.
module tb_axi_slave_mem_arb;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_bsel;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [63:0] mem_dout;

    logic        a_wr_ready, a_rd_ready, a_rd_valid, a_mem_wr, a_mem_rd, a_idle;
    logic [63:0] a_rd_data, a_mem_din;
    logic [23:0] a_mem_addr;
    logic [7:0]  a_mem_bsel;
    logic [31:0] a_wr_cnt, a_rd_cnt;

    logic        b_wr_ready, b_rd_ready, b_rd_valid, b_mem_wr, b_mem_rd, b_idle;
    logic [63:0] b_rd_data, b_mem_din;
    logic [23:0] b_mem_addr;
    logic [7:0]  b_mem_bsel;
    logic [31:0] b_wr_cnt, b_rd_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] stub_mem [0:63];
    logic [63:0] vals [0:2];

    axi_slave_mem_arb #(.ADDR_BITS(24), .DATA_BITS(64), .WR_PRIO(1'b0), .STARVE_MAX(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bsel(wr_bsel), .wr_ready(a_wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .mem_wr(a_mem_wr), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_bsel(a_mem_bsel),
        .mem_dout(mem_dout), .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt), .idle(a_idle)
    );

    axi_slave_mem_arb #(.ADDR_BITS(24), .DATA_BITS(64), .WR_PRIO(1'b1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bsel(wr_bsel), .wr_ready(b_wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_bsel(b_mem_bsel),
        .mem_dout(mem_dout), .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt), .idle(b_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub behind instance a: byte-masked writes, read data one cycle after mem_rd.
    always @(posedge clk) begin
        if (a_mem_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (a_mem_bsel[i]) stub_mem[a_mem_addr[8:3]][8*i +: 8] = a_mem_din[8*i +: 8];
            end
        end
        if (a_mem_rd) mem_dout <= stub_mem[a_mem_addr[8:3]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        wr_req = 1'b0;
        rd_req = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %0h want 0", a_mem_wr); end
        n_cmp++; if (a_mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd: got %0h want 0", a_mem_rd); end
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0h want 0", a_rd_valid); end
        n_cmp++; if (a_mem_addr !== 24'h0) begin n_err++; $display("FAIL reset_mem_addr: got %0h want 0", a_mem_addr); end
        n_cmp++; if (a_mem_din !== 64'h0) begin n_err++; $display("FAIL reset_mem_din: got %0h want 0", a_mem_din); end
        n_cmp++; if (a_mem_bsel !== 8'h0) begin n_err++; $display("FAIL reset_mem_bsel: got %0h want 0", a_mem_bsel); end
        n_cmp++; if (a_wr_cnt !== 32'h0) begin n_err++; $display("FAIL reset_wr_cnt: got %0h want 0", a_wr_cnt); end
        n_cmp++; if (a_rd_cnt !== 32'h0) begin n_err++; $display("FAIL reset_rd_cnt: got %0h want 0", a_rd_cnt); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %0h want 1", a_idle); end
        n_cmp++; if (b_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle_b: got %0h want 1", b_idle); end
        reset = 1'b0;
    endtask

    task automatic test_single_write;
        do_reset;
        wr_req = 1'b1; wr_addr = 24'h000010; wr_data = 64'h1122334455667788; wr_bsel = 8'hFF;
        #1;
        n_cmp++; if (a_wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %0h want 1", a_wr_ready); end
        n_cmp++; if (a_rd_ready !== 1'b0) begin n_err++; $display("FAIL wr_rd_ready: got %0h want 0", a_rd_ready); end
        n_cmp++; if (a_idle !== 1'b0) begin n_err++; $display("FAIL wr_idle: got %0h want 0", a_idle); end
        @(posedge clk); #1 wr_req = 1'b0;
        #1;
        n_cmp++; if (a_mem_wr !== 1'b1) begin n_err++; $display("FAIL wr_mem_wr: got %0h want 1", a_mem_wr); end
        n_cmp++; if (a_mem_rd !== 1'b0) begin n_err++; $display("FAIL wr_mem_rd: got %0h want 0", a_mem_rd); end
        n_cmp++; if (a_mem_addr !== 24'h000010) begin n_err++; $display("FAIL wr_mem_addr: got %0h want 10", a_mem_addr); end
        n_cmp++; if (a_mem_din !== 64'h1122334455667788) begin n_err++; $display("FAIL wr_mem_din: got %0h want 1122334455667788", a_mem_din); end
        n_cmp++; if (a_mem_bsel !== 8'hFF) begin n_err++; $display("FAIL wr_mem_bsel: got %0h want ff", a_mem_bsel); end
        n_cmp++; if (a_wr_cnt !== 32'd1) begin n_err++; $display("FAIL wr_cnt: got %0h want 1", a_wr_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (a_mem_wr !== 1'b0) begin n_err++; $display("FAIL wr_strobe_drop: got %0h want 0", a_mem_wr); end
        n_cmp++; if (a_mem_addr !== 24'h000010) begin n_err++; $display("FAIL wr_addr_hold: got %0h want 10", a_mem_addr); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL wr_idle_after: got %0h want 1", a_idle); end
    endtask

    task automatic test_single_read;
        stub_mem[2] = 64'hDEADBEEF_CAFEF00D;
        rd_req = 1'b1; rd_addr = 24'h000010;
        #1;
        n_cmp++; if (a_rd_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %0h want 1", a_rd_ready); end
        n_cmp++; if (a_wr_ready !== 1'b0) begin n_err++; $display("FAIL rd_wr_ready: got %0h want 0", a_wr_ready); end
        @(posedge clk); #1 rd_req = 1'b0;
        #1;
        n_cmp++; if (a_mem_rd !== 1'b1) begin n_err++; $display("FAIL rd_mem_rd: got %0h want 1", a_mem_rd); end
        n_cmp++; if (a_mem_addr !== 24'h000010) begin n_err++; $display("FAIL rd_mem_addr: got %0h want 10", a_mem_addr); end
        n_cmp++; if (a_mem_din !== 64'h1122334455667788) begin n_err++; $display("FAIL rd_din_hold: got %0h want 1122334455667788", a_mem_din); end
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_early: got %0h want 0", a_rd_valid); end
        n_cmp++; if (a_rd_cnt !== 32'd1) begin n_err++; $display("FAIL rd_cnt: got %0h want 1", a_rd_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid: got %0h want 1", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 64'hDEADBEEF_CAFEF00D) begin n_err++; $display("FAIL rd_data: got %0h want deadbeefcafef00d", a_rd_data); end
        n_cmp++; if (a_mem_rd !== 1'b0) begin n_err++; $display("FAIL rd_strobe_drop: got %0h want 0", a_mem_rd); end
        @(posedge clk); #1;
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_drop: got %0h want 0", a_rd_valid); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL rd_idle_after: got %0h want 1", a_idle); end
    endtask

    task automatic test_round_robin;
        logic exp_w;
        do_reset;
        wr_req = 1'b1; wr_addr = 24'h000100; wr_data = 64'h0; wr_bsel = 8'h01;
        rd_req = 1'b1; rd_addr = 24'h000108;
        for (int i = 0; i < 8; i++) begin
            exp_w = (i % 2 == 0);
            #1;
            n_cmp++; if (a_wr_ready !== exp_w) begin n_err++; $display("FAIL rr_wr_ready[%0d]: got %0h want %0h", i, a_wr_ready, exp_w); end
            n_cmp++; if (a_rd_ready !== !exp_w) begin n_err++; $display("FAIL rr_rd_ready[%0d]: got %0h want %0h", i, a_rd_ready, !exp_w); end
            n_cmp++; if (a_mem_wr && a_mem_rd) begin n_err++; $display("FAIL rr_strobes[%0d]: got both high want at most one", i); end
            @(posedge clk);
        end
        #1 wr_req = 1'b0; rd_req = 1'b0;
        #1;
        n_cmp++; if (a_wr_cnt !== 32'd4) begin n_err++; $display("FAIL rr_wr_cnt: got %0d want 4", a_wr_cnt); end
        n_cmp++; if (a_rd_cnt !== 32'd4) begin n_err++; $display("FAIL rr_rd_cnt: got %0d want 4", a_rd_cnt); end
    endtask

    task automatic test_write_prio;
        logic exp_r;
        do_reset;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_r = (i == 4) || (i == 9);
            #1;
            n_cmp++; if (b_rd_ready !== exp_r) begin n_err++; $display("FAIL wp_rd_ready[%0d]: got %0h want %0h", i, b_rd_ready, exp_r); end
            n_cmp++; if (b_wr_ready !== !exp_r) begin n_err++; $display("FAIL wp_wr_ready[%0d]: got %0h want %0h", i, b_wr_ready, !exp_r); end
            @(posedge clk); #1;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        n_cmp++; if (b_wr_cnt !== 32'd8) begin n_err++; $display("FAIL wp_wr_cnt: got %0d want 8", b_wr_cnt); end
        n_cmp++; if (b_rd_cnt !== 32'd2) begin n_err++; $display("FAIL wp_rd_cnt: got %0d want 2", b_rd_cnt); end
        // A gap in rd_req clears the starvation count: the read then waits four more ties.
        do_reset;
        wr_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req = (i != 2);
            exp_r = (i == 7);
            #1;
            n_cmp++; if (b_rd_ready !== exp_r) begin n_err++; $display("FAIL wp_clear_rd_ready[%0d]: got %0h want %0h", i, b_rd_ready, exp_r); end
            @(posedge clk); #1;
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic exp_v;
        do_reset;
        vals[0] = 64'h0123_4567_89AB_CDEF;
        vals[1] = 64'hFEDC_BA98_7654_3210;
        vals[2] = 64'h5A5A_A5A5_0F0F_F0F0;
        for (int k = 0; k < 3; k++) stub_mem[4 + k] = vals[k];
        for (int c = 0; c < 6; c++) begin
            rd_req  = (c < 3);
            rd_addr = 24'h000020 + 24'(8 * c);
            #1;
            if (c < 3) begin
                n_cmp++; if (a_rd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rd_ready[%0d]: got %0h want 1", c, a_rd_ready); end
            end
            @(posedge clk); #1;
            n_cmp++; if (a_mem_rd !== (c < 3)) begin n_err++; $display("FAIL b2b_mem_rd[%0d]: got %0h want %0h", c, a_mem_rd, (c < 3)); end
            exp_v = (c >= 1) && (c <= 3);
            n_cmp++; if (a_rd_valid !== exp_v) begin n_err++; $display("FAIL b2b_rd_valid[%0d]: got %0h want %0h", c, a_rd_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (a_rd_data !== vals[c - 1]) begin n_err++; $display("FAIL b2b_rd_data[%0d]: got %0h want %0h", c, a_rd_data, vals[c - 1]); end
            end
        end
        n_cmp++; if (a_rd_cnt !== 32'd3) begin n_err++; $display("FAIL b2b_rd_cnt: got %0d want 3", a_rd_cnt); end

        // Reset while reads are in flight: nothing may come back afterwards.
        do_reset;
        rd_req = 1'b1; rd_addr = 24'h000020;
        @(posedge clk); #1 rd_addr = 24'h000028;
        @(posedge clk); #1;
        n_cmp++; if (a_mem_rd !== 1'b1) begin n_err++; $display("FAIL rst_second_mem_rd: got %0h want 1", a_mem_rd); end
        reset = 1'b1; rd_req = 1'b0;
        #1;
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid: got %0h want 0", a_rd_valid); end
        n_cmp++; if (a_mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %0h want 0", a_mem_rd); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_valid[%0d]: got %0h want 0", c, a_rd_valid); end
        end
        n_cmp++; if (a_rd_cnt !== 32'd0) begin n_err++; $display("FAIL rst_rd_cnt: got %0d want 0", a_rd_cnt); end
        n_cmp++; if (a_wr_cnt !== 32'd0) begin n_err++; $display("FAIL rst_wr_cnt: got %0d want 0", a_wr_cnt); end
    endtask

    task automatic test_wr_then_rd;
        do_reset;
        stub_mem[8] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_req = 1'b1; wr_addr = 24'h000040; wr_data = 64'hAAAA_AAAA_5555_5555; wr_bsel = 8'h0F;
        #1;
        n_cmp++; if (a_wr_ready !== 1'b1) begin n_err++; $display("FAIL wtr_wr_ready: got %0h want 1", a_wr_ready); end
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b1; rd_addr = 24'h000040;
        #1;
        n_cmp++; if (a_rd_ready !== 1'b1) begin n_err++; $display("FAIL wtr_rd_ready: got %0h want 1", a_rd_ready); end
        n_cmp++; if (a_mem_bsel !== 8'h0F) begin n_err++; $display("FAIL wtr_mem_bsel: got %0h want 0f", a_mem_bsel); end
        @(posedge clk); #1 rd_req = 1'b0;
        #1;
        n_cmp++; if (a_mem_rd !== 1'b1) begin n_err++; $display("FAIL wtr_mem_rd: got %0h want 1", a_mem_rd); end
        @(posedge clk); #1;
        n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL wtr_rd_valid: got %0h want 1", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 64'hFFFF_FFFF_5555_5555) begin n_err++; $display("FAIL wtr_rd_data: got %0h want ffffffff55555555", a_rd_data); end
    endtask

    task automatic test_wrap;
        do_reset;
        force u_dut0.wr_cnt_q = 32'hFFFF_FFFF;
        #1 release u_dut0.wr_cnt_q;
        #1;
        n_cmp++; if (a_wr_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %0h want ffffffff", a_wr_cnt); end
        wr_req = 1'b1; wr_addr = 24'h000080; wr_data = 64'h1; wr_bsel = 8'h01;
        @(posedge clk); #1 wr_req = 1'b0;
        #1;
        n_cmp++; if (a_wr_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_wr_cnt: got %0h want 0", a_wr_cnt); end
        n_cmp++; if (a_rd_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_rd_cnt: got %0h want 0", a_rd_cnt); end
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_bsel = '0; rd_addr = '0;
        for (int i = 0; i < 64; i++) stub_mem[i] = 64'h0;
        test_reset;
        test_single_write;
        test_single_read;
        test_round_robin;
        test_write_prio;
        test_back_to_back;
        test_wr_then_rd;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
